mac_recv: RTL and testbench
===========================

// Module: mac_recv
// PURPOSE
// Ethernet MAC receive side, the counterpart of the MAC transmitter on the same byte-wide PHY path.
// Strips preamble/SFD, filters on destination MAC (local or broadcast) and captures source MAC and ethertype.
// Streams payload bytes with the 4-byte FCS withheld, then issues a single good or bad verdict per frame.
// Sits between the PHY receive byte interface and the IP/UDP/ARP receive decoders.
// PARAMETERS
// MAX_FRAME_LEN  1518  max bytes from dest MAC through FCS; a longer frame is a length error
// MIN_FRAME_LEN  64    min bytes from dest MAC through FCS; a shorter frame is a length error
// PORTS
// clock            in   1   rx byte clock
// reset            in   1   asynchronous, active-low reset
// rx_enable        in   1   PHY data valid; high for the whole frame, preamble included
// data_in          in   8   PHY rx byte
// local_mac        in   48  our MAC address, byte 0 is the first byte on the wire (bits 47:40)
// active           out  1   frame accepted by the filter and in progress
// data_out         out  8   payload byte (after ethertype, FCS excluded)
// data_valid       out  1   data_out is valid this cycle
// remote_mac       out  48  source MAC of the current frame, valid from the first data_valid onward
// ethertype        out  16  ethertype/length field, valid from the first data_valid onward
// broadcast        out  1   destination MAC was ff:ff:ff:ff:ff:ff
// frame_ok         out  1   one-cycle pulse: accepted frame ended, FCS and length good
// frame_err        out  1   one-cycle pulse: accepted frame ended, FCS, length or alignment bad
// BEHAVIOUR
// - Reset: all outputs 0, remote_mac/ethertype 0, state ST_IDLE, byte counter 0.
// - States ST_IDLE, ST_PREAMBLE, ST_HEADER, ST_PAYLOAD, ST_DROP:
//   ST_IDLE -> ST_PREAMBLE when rx_enable && data_in==8'h55.
//   ST_PREAMBLE: 8'h55 stays; 8'hD5 -> ST_HEADER; any other byte -> ST_DROP.
//   ST_HEADER: 14 bytes. Bytes 0-5 are compared against local_mac and broadcast. On mismatch after byte 5 -> ST_DROP.
//     Bytes 6-11 -> remote_mac; bytes 12-13 -> ethertype; then -> ST_PAYLOAD.
//   ST_PAYLOAD: runs until rx_enable falls, then returns to ST_IDLE with a verdict.
//   ST_DROP: waits for rx_enable low, then -> ST_IDLE. Never emits data, frame_ok or frame_err.
// - rx_enable falling in ST_PREAMBLE or ST_HEADER -> ST_IDLE silently; a frame that has not passed the filter gets no verdict.
// - active is high from the cycle after the filter passes until the verdict cycle, inclusive.
// - FCS: every post-SFD byte enters a 4-byte delay line.
//   Each byte leaving the line feeds the CRC, and payload bytes leaving it drive data_out/data_valid.
//   Payload latency is therefore 4 byte-cycles plus 1 register; the last 4 bytes (FCS) are never emitted.
// - At rx_enable fall, the delay line holds the FCS. Good iff line == {crc[7:0],crc[15:8],crc[23:16],crc[31:24]},
//   which is the transmitter byte order.
// - Verdict is issued the cycle after rx_enable falls: exactly one of frame_ok/frame_err pulses.
//   frame_err also fires for length < MIN_FRAME_LEN, length > MAX_FRAME_LEN (counter saturates, no wrap),
//   and for frames shorter than 14+4 post-SFD bytes.
// - A frame that exceeds MAX_FRAME_LEN keeps streaming until rx_enable falls; the consumer discards on frame_err.
// - rx_enable re-rising on the verdict cycle is treated as a new preamble.
// - Reset mid-frame: immediate return to ST_IDLE, outputs cleared, no verdict.
// CONFIGURATION
// - MAC_RECV_PROMISC_EN defined: destination filter bypassed; every frame is accepted, and broadcast is still reported.
// - Not defined: only a local_mac or broadcast destination is accepted; other frames go to ST_DROP.
// STRUCTURE
// - mac_defs.vh shared include: ETH_HDR_LEN=14, ETH_FCS_LEN=4, BROADCAST_MAC=48'hFFFF_FFFF_FFFF,
//   PREAMBLE_BYTE=8'h55, SFD_BYTE=8'hD5, state encodings. The transmitter uses the same include.
// - Sub-module: the existing crc32 (clock/clear/enable/data/result).
//   clear is driven while not in ST_HEADER/ST_PAYLOAD; enable is driven when a byte leaves the delay line.
// TESTING
// 1. Unicast 64-byte frame to local_mac with correct FCS -> 46 data_valid bytes, remote_mac/ethertype
//    captured, frame_ok=1 once, frame_err never.
// 2. Same frame with one payload bit flipped -> identical data stream, frame_err=1 once, frame_ok never.
// 3. Frame to 02:00:00:00:00:99 while local_mac differs -> active, data_valid, frame_ok and frame_err all stay 0.
//    With MAC_RECV_PROMISC_EN: accepted, frame_ok=1.
// 4. Broadcast ARP (ethertype 16'h0806) of 60+4 bytes -> broadcast=1, frame_ok=1.
//    A 1519-byte frame -> frame_err=1. A 40-byte frame -> frame_err=1.
// 5. Preamble 55 55 A5 -> ST_DROP, no outputs. rx_enable dropped at header byte 9 -> no verdict, idle next cycle.
// 6. reset low mid-payload, then a clean frame -> no verdict for the first frame, frame_ok for the second.
//    Back-to-back frames with 1 idle cycle -> two frame_ok pulses.

Source files
------------

// File: rtl/mac_recv_pkg.sv
// Shared Ethernet receive definitions: frame constants, FSM state encoding and
// byte-wise helpers for MAC addresses and the reflected CRC-32.
package mac_recv_pkg;

   localparam int ETH_HDR_LEN = 14;
   localparam int ETH_FCS_LEN = 4;
   localparam int ETH_MAC_LEN = 6;

   localparam logic [47:0] BROADCAST_MAC = 48'hFFFF_FFFF_FFFF;
   localparam logic [7:0]  PREAMBLE_BYTE = 8'h55;
   localparam logic [7:0]  SFD_BYTE      = 8'hD5;
   localparam logic [31:0] CRC32_POLY    = 32'hEDB8_8320;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_PREAMBLE,
      ST_HEADER,
      ST_PAYLOAD,
      ST_DROP
   } state_t;

   // Byte idx of a MAC address in wire order (byte 0 = bits 47:40).
   function automatic logic [7:0] mac_byte(input logic [47:0] mac, input logic [2:0] idx);
      logic [47:0] s;
      s = mac << {idx, 3'b000};
      return s[47:40];
   endfunction

   function automatic logic [31:0] crc32_byte(input logic [31:0] crc, input logic [7:0] data);
      logic [31:0] c;
      c = crc ^ {24'h0, data};
      for (int i = 0; i < 8; i++)
         c = c[0] ? ({1'b0, c[31:1]} ^ CRC32_POLY) : {1'b0, c[31:1]};
      return c;
   endfunction

endpackage

// File: rtl/mac_recv_crc32.sv
// Ethernet CRC-32 accumulator, one byte per enabled cycle, LSB-first on the wire.
// result is the complemented running CRC, i.e. the FCS value for the bytes so far.
module mac_recv_crc32
   import mac_recv_pkg::*;
(
   input  logic        clock,
   input  logic        reset,
   input  logic        clear,
   input  logic        enable,
   input  logic [7:0]  data,
   output logic [31:0] result
);

   logic [31:0] crc;

   // NOTE: state registers use non-blocking (<=) so every flop samples pre-edge values.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset)
         crc <= '1;
      else if (clear)
         crc <= '1;
      else if (enable)
         crc <= crc32_byte(crc, data);
   end

   assign result = ~crc;

endmodule

// File: rtl/mac_recv.sv
// Ethernet MAC receiver: preamble/SFD strip, destination filter, header capture,
// FCS-withheld payload stream and one good/bad verdict per accepted frame.
// Build option: define MAC_RECV_PROMISC_EN to accept every destination address.
module mac_recv
   import mac_recv_pkg::*;
#(
   parameter int MAX_FRAME_LEN = 1518,
   parameter int MIN_FRAME_LEN = 64
) (
   input  logic        clock,
   input  logic        reset,
   input  logic        rx_enable,
   input  logic [7:0]  data_in,
   input  logic [47:0] local_mac,
   output logic        active,
   output logic [7:0]  data_out,
   output logic        data_valid,
   output logic [47:0] remote_mac,
   output logic [15:0] ethertype,
   output logic        broadcast,
   output logic        frame_ok,
   output logic        frame_err
);

   localparam int CNT_W = $clog2(MAX_FRAME_LEN + 2);
   localparam logic [CNT_W-1:0] CNT_SAT    = CNT_W'(MAX_FRAME_LEN + 1);
   localparam logic [CNT_W-1:0] CNT_MAX    = CNT_W'(MAX_FRAME_LEN);
   localparam logic [CNT_W-1:0] CNT_MIN    = CNT_W'(MIN_FRAME_LEN);
   localparam logic [CNT_W-1:0] MAC_LAST   = CNT_W'(ETH_MAC_LEN - 1);
   localparam logic [CNT_W-1:0] SRC_LAST   = CNT_W'(2 * ETH_MAC_LEN - 1);
   localparam logic [CNT_W-1:0] HDR_LAST   = CNT_W'(ETH_HDR_LEN - 1);
   localparam logic [CNT_W-1:0] FCS_LEN    = CNT_W'(ETH_FCS_LEN);
   localparam logic [CNT_W-1:0] DATA_FIRST = CNT_W'(ETH_HDR_LEN + ETH_FCS_LEN);

   state_t           state, next_state;
   logic [CNT_W-1:0] count;
   logic [31:0]      line;
   logic [31:0]      crc;
   logic             uni_ok, bc_ok;
   logic             uni_hit, bc_hit, pass;
   logic             sfd, accept, verdict, abort;
   logic             take, crc_clear, crc_enable, good;

   // Match flags accumulate over destination bytes 0-5; the hit terms fold in the current byte.
   assign uni_hit = uni_ok && (data_in == mac_byte(local_mac, count[2:0]));
   assign bc_hit  = bc_ok && (data_in == BROADCAST_MAC[7:0]);
`ifdef MAC_RECV_PROMISC_EN
   assign pass = 1'b1;
`else
   assign pass = uni_hit || bc_hit;
`endif

   assign take       = rx_enable && (state == ST_HEADER || state == ST_PAYLOAD);
   assign crc_clear  = !(state == ST_HEADER || state == ST_PAYLOAD);
   assign crc_enable = take && (count >= FCS_LEN);

   // The delay line holds the FCS once rx_enable drops; first FCS byte sits in line[31:24].
   assign good = (line == {crc[7:0], crc[15:8], crc[23:16], crc[31:24]})
              && (count >= DATA_FIRST) && (count >= CNT_MIN) && (count <= CNT_MAX);

   mac_recv_crc32 u_crc (
      .clock  (clock),
      .reset  (reset),
      .clear  (crc_clear),
      .enable (crc_enable),
      .data   (line[31:24]),
      .result (crc)
   );

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) state <= ST_IDLE;
      else        state <= next_state;
   end

   // NOTE: every always_comb output gets a default first so no path can infer a latch.
   always_comb begin
      next_state = state;
      sfd        = 1'b0;
      accept     = 1'b0;
      verdict    = 1'b0;
      abort      = 1'b0;
      case (state)
         ST_IDLE:
            if (rx_enable && data_in == PREAMBLE_BYTE) next_state = ST_PREAMBLE;
         ST_PREAMBLE:
            if (!rx_enable)
               next_state = ST_IDLE;
            else if (data_in == SFD_BYTE) begin
               next_state = ST_HEADER;
               sfd        = 1'b1;
            end else if (data_in != PREAMBLE_BYTE)
               next_state = ST_DROP;
         ST_HEADER:
            if (!rx_enable) begin
               next_state = ST_IDLE;
               abort      = 1'b1;
            end else if (count == MAC_LAST) begin
               if (pass) accept = 1'b1;
               else      next_state = ST_DROP;
            end else if (count == HDR_LAST)
               next_state = ST_PAYLOAD;
         ST_PAYLOAD:
            if (!rx_enable) begin
               next_state = ST_IDLE;
               verdict    = 1'b1;
            end
         ST_DROP:
            if (!rx_enable) next_state = ST_IDLE;
         default:
            next_state = ST_IDLE;
      endcase
   end

   // NOTE: the 4-byte delay line is plain flops, so it is reset with everything else.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         count      <= '0;
         line       <= '0;
         uni_ok     <= 1'b0;
         bc_ok      <= 1'b0;
         active     <= 1'b0;
         data_out   <= '0;
         data_valid <= 1'b0;
         remote_mac <= '0;
         ethertype  <= '0;
         broadcast  <= 1'b0;
         frame_ok   <= 1'b0;
         frame_err  <= 1'b0;
      end else begin
         data_valid <= 1'b0;
         frame_ok   <= 1'b0;
         frame_err  <= 1'b0;
         if (sfd) begin
            count     <= '0;
            uni_ok    <= 1'b1;
            bc_ok     <= 1'b1;
            broadcast <= 1'b0;
         end
         if (take) begin
            line <= {line[23:0], data_in};
            if (count != CNT_SAT) count <= count + 1'b1;
            if (state == ST_HEADER) begin
               if (count <= MAC_LAST) begin
                  uni_ok <= uni_hit;
                  bc_ok  <= bc_hit;
               end else if (count <= SRC_LAST)
                  remote_mac <= {remote_mac[39:0], data_in};
               else
                  ethertype <= {ethertype[7:0], data_in};
            end
            if (state == ST_PAYLOAD && count >= DATA_FIRST) begin
               data_out   <= line[31:24];
               data_valid <= 1'b1;
            end
         end
         if (accept) begin
            active    <= 1'b1;
            broadcast <= bc_hit;
         end
         if (verdict) begin
            frame_ok  <= good;
            frame_err <= !good;
         end
         // active covers the verdict cycle, then drops.
         if (abort || frame_ok || frame_err) active <= 1'b0;
      end
   end

endmodule

// File: tb/tb_mac_recv.sv
// Directed self-checking bench for mac_recv: frames are built with a bit-serial
// reference CRC and the monitor tallies payload bytes and verdict pulses.
module tb_mac_recv;

   localparam logic [47:0] LOCAL = 48'h02_00_00_00_00_01;
   localparam logic [47:0] OTHER = 48'h02_00_00_00_00_99;
   localparam logic [47:0] BCAST = 48'hFF_FF_FF_FF_FF_FF;
   localparam logic [47:0] SRC   = 48'h02_11_22_33_44_55;

   logic        clock = 1'b0;
   logic        reset = 1'b0;
   logic        rx_enable = 1'b0;
   logic [7:0]  data_in = 8'h00;
   logic [47:0] local_mac = LOCAL;
   logic        active, data_valid, broadcast, frame_ok, frame_err;
   logic [7:0]  data_out;
   logic [47:0] remote_mac;
   logic [15:0] ethertype;

   mac_recv dut (
      .clock      (clock),
      .reset      (reset),
      .rx_enable  (rx_enable),
      .data_in    (data_in),
      .local_mac  (local_mac),
      .active     (active),
      .data_out   (data_out),
      .data_valid (data_valid),
      .remote_mac (remote_mac),
      .ethertype  (ethertype),
      .broadcast  (broadcast),
      .frame_ok   (frame_ok),
      .frame_err  (frame_err)
   );

   always #5 clock = ~clock;

   int checks = 0;
   int errors = 0;

   // Monitor: sole writer of the cumulative tallies, sampled on the falling edge.
   logic [7:0] rx_q[$];
   int ok_total = 0, err_total = 0, act_total = 0;
   always @(negedge clock) begin
      if (data_valid) rx_q.push_back(data_out);
      if (frame_ok)   ok_total++;
      if (frame_err)  err_total++;
      if (active)     act_total++;
   end

   int ok0, err0, act0, rx0;
   task automatic snap();
      ok0 = ok_total; err0 = err_total; act0 = act_total; rx0 = rx_q.size();
   endtask

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   logic [7:0] tx[$];

   function automatic logic [31:0] fcs_of();
      logic [31:0] c;
      logic        fb;
      c = 32'hFFFF_FFFF;
      foreach (tx[i])
         for (int b = 0; b < 8; b++) begin
            fb = c[0] ^ tx[i][b];
            c  = {1'b0, c[31:1]};
            if (fb) c = c ^ 32'hEDB8_8320;
         end
      return ~c;
   endfunction

   task automatic build(input logic [47:0] dst, input int plen, input logic [15:0] etype,
                        input logic [7:0] seed);
      logic [31:0] f;
      tx.delete();
      for (int i = 0; i < 6; i++) tx.push_back(dst[47-8*i -: 8]);
      for (int i = 0; i < 6; i++) tx.push_back(SRC[47-8*i -: 8]);
      tx.push_back(etype[15:8]);
      tx.push_back(etype[7:0]);
      for (int i = 0; i < plen; i++) tx.push_back(8'(seed + 8'(i * 7)));
      f = fcs_of();
      tx.push_back(f[7:0]);
      tx.push_back(f[15:8]);
      tx.push_back(f[23:16]);
      tx.push_back(f[31:24]);
   endtask

   task automatic drive(input logic en, input logic [7:0] d);
      @(posedge clock);
      #1;
      rx_enable = en;
      data_in   = d;
   endtask

   task automatic send_partial(input int n);
      for (int i = 0; i < 7; i++) drive(1'b1, 8'h55);
      drive(1'b1, 8'hD5);
      for (int i = 0; i < n; i++) drive(1'b1, tx[i]);
   endtask

   task automatic send_frame(input int idle_after);
      send_partial(tx.size());
      drive(1'b0, 8'h00);
      repeat (idle_after) drive(1'b0, 8'h00);
   endtask

   task automatic check_stream(input string tag, input int plen);
      check({tag, "_count"}, 64'(rx_q.size() - rx0), 64'(plen));
      for (int i = 0; i < plen && rx0 + i < rx_q.size(); i++)
         check({tag, "_byte"}, 64'(rx_q[rx0+i]), 64'(tx[14+i]));
   endtask

   initial begin
      // Reset state
      repeat (3) @(posedge clock);
      @(negedge clock);
      check("rst_active", 64'(active), 0);
      check("rst_valid", 64'(data_valid), 0);
      check("rst_ok_err", 64'({frame_ok, frame_err}), 0);
      check("rst_remote", 64'(remote_mac), 0);
      check("rst_etype", 64'(ethertype), 0);
      check("rst_bcast", 64'(broadcast), 0);
      reset = 1'b1;
      drive(1'b0, 8'h00);

      // 1: unicast 64-byte frame, exact verdict timing
      build(LOCAL, 46, 16'h0800, 8'h10);
      snap();
      send_frame(0);
      @(negedge clock);
      check("t1_no_early_verdict", 64'(frame_ok), 0);
      check("t1_active_in_frame", 64'(active), 1);
      @(negedge clock);
      check("t1_ok_pulse", 64'(frame_ok), 1);
      check("t1_err_low", 64'(frame_err), 0);
      check("t1_active_verdict", 64'(active), 1);
      @(negedge clock);
      check("t1_ok_one_cycle", 64'(frame_ok), 0);
      check("t1_active_off", 64'(active), 0);
      check("t1_ok_count", 64'(ok_total - ok0), 1);
      check("t1_err_count", 64'(err_total - err0), 0);
      check_stream("t1", 46);
      check("t1_remote", 64'(remote_mac), 64'(SRC));
      check("t1_etype", 64'(ethertype), 64'h0800);
      check("t1_bcast", 64'(broadcast), 0);

      // 2: same frame with one payload bit flipped
      tx[24] = tx[24] ^ 8'h04;
      snap();
      send_frame(3);
      check("t2_ok_count", 64'(ok_total - ok0), 0);
      check("t2_err_count", 64'(err_total - err0), 1);
      check_stream("t2", 46);

      // 3: foreign destination
      build(OTHER, 46, 16'h0800, 8'h33);
      snap();
      send_frame(3);
`ifdef MAC_RECV_PROMISC_EN
      check("t3_ok_count", 64'(ok_total - ok0), 1);
      check_stream("t3", 46);
`else
      check("t3_ok_count", 64'(ok_total - ok0), 0);
      check("t3_rx_count", 64'(rx_q.size() - rx0), 0);
      check("t3_active", 64'(act_total - act0), 0);
`endif
      check("t3_err_count", 64'(err_total - err0), 0);

      // 4: broadcast ARP, oversize and undersize frames
      build(BCAST, 46, 16'h0806, 8'h5A);
      snap();
      send_frame(3);
      check("t4_bcast", 64'(broadcast), 1);
      check("t4_arp_ok", 64'(ok_total - ok0), 1);
      check("t4_arp_etype", 64'(ethertype), 64'h0806);
      build(LOCAL, 1501, 16'h0800, 8'h01);
      snap();
      send_frame(3);
      check("t4_long_err", 64'(err_total - err0), 1);
      check("t4_long_ok", 64'(ok_total - ok0), 0);
      check("t4_long_stream", 64'(rx_q.size() - rx0), 1501);
      build(LOCAL, 22, 16'h0800, 8'h77);
      snap();
      send_frame(3);
      check("t4_short_err", 64'(err_total - err0), 1);
      check("t4_short_ok", 64'(ok_total - ok0), 0);

      // 5: bad preamble byte, then header abort at byte 9
      build(LOCAL, 46, 16'h0800, 8'h21);
      snap();
      drive(1'b1, 8'h55);
      drive(1'b1, 8'h55);
      drive(1'b1, 8'hA5);
      drive(1'b1, 8'hD5);
      foreach (tx[i]) drive(1'b1, tx[i]);
      repeat (3) drive(1'b0, 8'h00);
      check("t5_drop_verdicts", 64'((ok_total - ok0) + (err_total - err0)), 0);
      check("t5_drop_rx", 64'(rx_q.size() - rx0), 0);
      check("t5_drop_active", 64'(act_total - act0), 0);
      snap();
      send_partial(9);
      drive(1'b0, 8'h00);
      @(negedge clock);
      @(negedge clock);
      check("t5_abort_idle", 64'(active), 0);
      repeat (3) drive(1'b0, 8'h00);
      check("t5_abort_verdicts", 64'((ok_total - ok0) + (err_total - err0)), 0);

      // 6: reset mid-payload, then a clean frame; back-to-back frames
      build(LOCAL, 46, 16'h0800, 8'h42);
      snap();
      send_partial(34);
      @(posedge clock);
      #1;
      reset = 1'b0;
      @(negedge clock);
      check("t6_rst_active", 64'(active), 0);
      check("t6_rst_valid", 64'(data_valid), 0);
      check("t6_rst_remote", 64'(remote_mac), 0);
      drive(1'b0, 8'h00);
      drive(1'b0, 8'h00);
      reset = 1'b1;
      drive(1'b0, 8'h00);
      send_frame(3);
      check("t6_clean_ok", 64'(ok_total - ok0), 1);
      check("t6_clean_err", 64'(err_total - err0), 0);
      snap();
      build(LOCAL, 46, 16'h0800, 8'h90);
      send_frame(0);
      build(BCAST, 50, 16'h0806, 8'hA0);
      send_frame(3);
      check("t6_b2b_ok", 64'(ok_total - ok0), 2);
      check("t6_b2b_err", 64'(err_total - err0), 0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
